// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: sequential PC generation, credit-limited requests to an
// in-order variable-latency memory, and a DEPTH-entry instruction queue toward decode.
module fetch_queue_unit #(
    parameter int unsigned        XLEN     = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [XLEN-1:0]    RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc4
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned UW = CW + 1;

    logic [31:0]     instr_q [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [PW-1:0]   rptr;
    logic [PW-1:0]   wptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;

    logic            issue;
    logic            rsp_hit;
    logic            push;
    logic            pop;
    logic [UW-1:0]   used;
    logic [XLEN-1:0] target_pc;

    // Dropped in-flight requests still hold a credit, so the queue can never overflow.
    assign used      = UW'(count) + UW'(inflight);
    assign imem_req  = rst && !redirect && (used < UW'(DEPTH));
    assign imem_addr = fetch_pc;
    assign target_pc = redirect_pc & ~XLEN'(3);

    assign issue   = imem_req && imem_gnt;
    assign rsp_hit = imem_rvalid && (inflight != '0);
    assign push    = rsp_hit && (drop == '0) && !redirect;
    assign pop     = out_valid && out_ready;

    assign out_valid = (count != '0);
    assign out_instr = out_valid ? instr_q[rptr] : '0;
    assign out_pc    = out_valid ? pc_q[rptr] : '0;
    assign out_pc4   = out_valid ? pc_q[rptr] + XLEN'(4) : '0;

    // Control state; a redirect flushes the queue and converts all in-flight fetches to drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            count    <= '0;
            rptr     <= '0;
            wptr     <= '0;
        end else if (redirect) begin
            fetch_pc <= target_pc;
            rsp_pc   <= target_pc;
            inflight <= inflight - CW'(rsp_hit);
            drop     <= inflight - CW'(rsp_hit);
            count    <= '0;
            rptr     <= '0;
            wptr     <= '0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            inflight <= inflight + CW'(issue) - CW'(rsp_hit);
            if (rsp_hit && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
            if (push) begin
                rsp_pc <= rsp_pc + XLEN'(4);
                wptr   <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Queue storage; contents are only visible through the gated head outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wptr] <= imem_rdata;
            pc_q[wptr]    <= rsp_pc;
        end
    end

endmodule
